// File: rtl/mmio_timer_responder.sv
// MMIO timer peripheral behind a select/ready bus: CTRL/COUNT/COMPARE/STATUS registers,
// programmable wait states, compare-match flag with optional auto-reload and interrupt.
module mmio_timer_responder #(
  parameter logic [1:0]  SLOT_ID     = 2'd1,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic        pwrite_read,
  input  logic [1:0]  pselect,
  output logic [31:0] readdata,
  output logic        pready,
  output logic        pactive,
  output logic        irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_COUNT   = 2'd1;
  localparam logic [1:0] OFF_COMPARE = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]  r_state;
  logic [3:0]  r_wcnt;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic        r_wr;

  logic [2:0]  r_ctrl;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_match;
  logic        r_irq;

  logic        w_wr_en;
  logic        w_match;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  assign w_unused_addr = ^{addr[31:4], addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_off   <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pselect == SLOT_ID) begin
            r_off   <= addr[3:2];
            r_wdata <= writedata;
            r_wr    <= pwrite_read;
            if (WAIT_CYCLES > 0) begin
              r_state <= S_WAIT;
              r_wcnt  <= WAIT_LOAD;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (r_wcnt == '0) r_state <= S_RESP;
          else              r_wcnt  <= r_wcnt - 4'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_wr_en = (r_state == S_RESP) && r_wr;
  assign w_match = r_ctrl[0] && (r_count == r_compare);

  // Bus write to COUNT beats reload/increment; a fresh match beats a W1C clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl    <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_match   <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_en && r_off == OFF_CTRL)    r_ctrl    <= r_wdata[2:0];
      if (w_wr_en && r_off == OFF_COMPARE) r_compare <= r_wdata;
      if (w_wr_en && r_off == OFF_COUNT)   r_count   <= r_wdata;
      else if (r_ctrl[0])                  r_count   <= (w_match && r_ctrl[1]) ? '0 : r_count + 32'd1;
      if (w_match)                                            r_match <= 1'b1;
      else if (w_wr_en && r_off == OFF_STATUS && r_wdata[0])  r_match <= 1'b0;
      r_irq <= r_match & r_ctrl[2];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_state == S_RESP && !r_wr) begin
      case (r_off)
        OFF_CTRL:    w_rdata = {29'd0, r_ctrl};
        OFF_COUNT:   w_rdata = r_count;
        OFF_COMPARE: w_rdata = r_compare;
        OFF_STATUS:  w_rdata = {31'd0, r_match};
        default:     w_rdata = '0;
      endcase
    end
  end

  assign readdata = w_rdata;
  assign pready   = (r_state == S_RESP);
  assign pactive  = (r_state == S_WAIT) || (r_state == S_RESP);
  assign irq      = r_irq;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed bench for mmio_timer_responder (SLOT_ID=1, WAIT_CYCLES=1); inputs change and
// outputs are sampled on the falling edge.
module tb_mmio_timer_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] writedata = '0;
  logic        pwrite_read = 1'b0;
  logic [1:0]  pselect = '0;
  logic [31:0] readdata;
  logic        pready;
  logic        pactive;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  mmio_timer_responder #(.SLOT_ID(2'd1), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .writedata(writedata),
    .pwrite_read(pwrite_read), .pselect(pselect), .readdata(readdata),
    .pready(pready), .pactive(pactive), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transfer; inputs are scrambled after the select edge so only latched values matter.
  task automatic xfer(input logic wr, input logic [1:0] off, input logic [31:0] data,
                      output logic [31:0] rd, output int lat, output int act);
    bit done;
    @(negedge clk);
    pselect = 2'd1; addr = {28'hA5A5F0F, off, 2'b10}; writedata = data; pwrite_read = wr;
    @(posedge clk);
    @(negedge clk);
    pselect = 2'd0; addr = ~addr; writedata = ~data; pwrite_read = ~wr;
    lat = 0; act = 0; rd = '0; done = 1'b0;
    while (!done && lat < 16) begin
      lat++;
      if (pactive) act++;
      if (pready) begin
        rd = readdata;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("xfer_done", {31'd0, done}, 32'd1);
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [31:0] data);
    logic [31:0] rd; int lat; int act;
    xfer(1'b1, off, data, rd, lat, act);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] rd; int lat; int act;
    xfer(1'b0, off, 32'h5A5A5A5A, rd, lat, act);
    chk(tag, rd, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat, act;
    logic seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pready",   {31'd0, pready},  32'd0);
    chk("rst_pactive",  {31'd0, pactive}, 32'd0);
    chk("rst_readdata", readdata,         32'd0);
    chk("rst_irq",      {31'd0, irq},     32'd0);
    reset = 1'b0;

    // Write/read timing
    xfer(1'b1, 2'd2, 32'h10, rd, lat, act);
    chk("wr_latency", lat, 32'd2);
    chk("wr_pactive", act, 32'd2);
    chk("wr_rdata0",  rd,  32'd0);
    xfer(1'b0, 2'd2, 32'hFFFF_0000, rd, lat, act);
    chk("rd_latency", lat, 32'd2);
    chk("rd_pactive", act, 32'd2);
    chk("rd_compare", rd,  32'h10);
    @(negedge clk);
    chk("rdata_idle",   readdata,         32'd0);
    chk("pactive_idle", {31'd0, pactive}, 32'd0);
    wr_reg(2'd0, 32'hFFFF_FFF8);
    rd_chk("ctrl_upper0", 2'd0, 32'd0);
    rd_chk("status_rst",  2'd3, 32'd0);
    rd_chk("count_rst",   2'd1, 32'd0);

    // Auto-reload: counts 0..5 then back to 0
    wr_reg(2'd2, 32'd5);
    wr_reg(2'd0, 32'h3);
    rd_chk("ar_count_a", 2'd1, 32'd2);
    rd_chk("ar_count_b", 2'd1, 32'd5);
    rd_chk("ar_count_c", 2'd1, 32'd2);
    rd_chk("ar_status",  2'd3, 32'd1);
    chk("ar_irq0", {31'd0, irq}, 32'd0);
    wr_reg(2'd0, 32'h0);
    wr_reg(2'd3, 32'h1);
    rd_chk("ar_status_clr", 2'd3, 32'd0);

    // Interrupt and W1C
    wr_reg(2'd1, 32'd0);
    wr_reg(2'd2, 32'd3);
    wr_reg(2'd0, 32'h5);
    repeat (5) @(negedge clk);
    chk("irq_lag",  {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    wr_reg(2'd3, 32'hFFFF_FFFE);
    rd_chk("w1c_zero_noop", 2'd3, 32'd1);
    wr_reg(2'd3, 32'h1);
    @(negedge clk);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_fall", {31'd0, irq}, 32'd0);
    rd_chk("w1c_status", 2'd3, 32'd0);

    // Wrap and write/increment collision
    wr_reg(2'd0, 32'h0);
    wr_reg(2'd1, 32'hFFFF_FFFF);
    wr_reg(2'd2, 32'h1000);
    wr_reg(2'd0, 32'h1);
    rd_chk("wrap_count", 2'd1, 32'd1);
    wr_reg(2'd1, 32'h100);
    rd_chk("collide_count", 2'd1, 32'h102);

    // Foreign select values never start a transfer
    wr_reg(2'd0, 32'h0);
    for (int s = 0; s < 4; s++) begin
      if (s == 1) continue;
      @(negedge clk);
      pselect = 2'(s); addr = 32'h8; writedata = 32'hDEAD; pwrite_read = 1'b1;
      seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (pactive || pready) seen = 1'b1;
      end
      chk($sformatf("badsel_%0d", s), {31'd0, seen}, 32'd0);
    end
    pselect = 2'd0;
    rd_chk("badsel_compare", 2'd2, 32'h1000);

    // Reset in the middle of WAIT aborts the write
    @(negedge clk);
    pselect = 2'd1; addr = 32'h8; writedata = 32'hABCD; pwrite_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pselect = 2'd0;
    chk("abort_in_wait", {31'd0, pactive}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_pactive", {31'd0, pactive}, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pready) seen = 1'b1;
    end
    chk("abort_no_pready", {31'd0, seen}, 32'd0);
    reset = 1'b0;
    xfer(1'b0, 2'd2, 32'h0, rd, lat, act);
    chk("post_rst_latency", lat, 32'd2);
    chk("abort_compare",    rd,  32'd0);
    rd_chk("post_rst_count", 2'd1, 32'd0);
    rd_chk("post_rst_ctrl",  2'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_timer_responder.md
MMIO_TIMER_RESPONDER -- requirements
Module: mmio_timer_responder

Interface
REQ-001 Parameter SLOT_ID, default 2'd1: value of pselect that addresses this peripheral.
REQ-002 Parameter WAIT_CYCLES, default 1, legal range 0..15: number of wait-state cycles inserted before pready.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 addr  input  32  bus address; only addr[3:2] is decoded as the register offset, and all other bits are ignored.
REQ-006 writedata  input  32  bus write data.
REQ-007 pwrite_read  input  1  1 = write transfer, 0 = read transfer.
REQ-008 pselect  input  2  peripheral select from the bus controller; 0 = no transfer.
REQ-009 readdata  output  32  read data; valid only while pready=1 on a read transfer.
REQ-010 pready  output  1  transfer-complete strobe, one cycle wide.
REQ-011 pactive  output  1  high while this peripheral owns a transfer.
REQ-012 irq  output  1  interrupt request, level, registered.

Function
REQ-013 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-014 IDLE: when pselect==SLOT_ID, the block SHALL latch addr[3:2], writedata and pwrite_read, and go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-015 WAIT: the wait counter SHALL load WAIT_CYCLES-1 on entry, decrement each cycle, and cause a transition to RESP when it reaches 0.
REQ-016 RESP: the block SHALL hold pready=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-017 The block SHALL drive pactive=1 in WAIT and RESP, and 0 in IDLE.
REQ-018 The block SHALL ignore changes on pselect, addr, writedata and pwrite_read in WAIT and RESP, and use only the latched values.
REQ-019 On return to IDLE with pselect still ==SLOT_ID, the block SHALL start a new transfer in that same cycle.
REQ-020 Latency SHALL be WAIT_CYCLES+1 cycles from the select-sampling edge to pready=1.
REQ-021 Register map (offset addr[3:2]): 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS.
REQ-022 CTRL SHALL be 3 bits: bit0 enable, bit1 auto_reload, bit2 irq_enable; upper bits SHALL read as 0.
REQ-023 COUNT SHALL be 32 bits and read/write.
REQ-024 COMPARE SHALL be 32 bits and read/write.
REQ-025 STATUS bit0 SHALL be the match flag, write-1-to-clear; writing 0 SHALL have no effect, and upper bits SHALL read as 0.
REQ-026 Register writes SHALL commit on the clock edge ending the RESP cycle.
REQ-027 A read SHALL drive readdata with the register value current during the RESP cycle; readdata SHALL be 0 in all other cycles.
REQ-028 When enable=1, COUNT SHALL increment by 1 every cycle, wrapping from 0xFFFFFFFF to 0.
REQ-029 Match condition: enable=1 and COUNT==COMPARE; on match, STATUS.match SHALL be set on the next edge.
REQ-030 On match with auto_reload=1, COUNT SHALL load 0 instead of incrementing.
REQ-031 A bus write to COUNT SHALL take priority over increment and reload in the same cycle.
REQ-032 A new match SHALL take priority over a simultaneous W1C of STATUS, leaving the flag set.
REQ-033 irq SHALL be a registered copy of (STATUS.match & CTRL.irq_enable), i.e. one cycle after either term changes.

Reset
REQ-034 On reset assertion the block SHALL immediately set state=IDLE, pready=0, pactive=0, readdata=0, irq=0, CTRL=0, COUNT=0, COMPARE=0, STATUS=0, and clear the wait counter.
REQ-035 A reset during WAIT or RESP SHALL abort the transfer with no register write and no pready pulse.
REQ-036 After reset deasserts, the first transfer SHALL be accepted on the first edge with pselect==SLOT_ID.

Verification
REQ-037 Write/read timing, WAIT_CYCLES=1: write COMPARE=0x10, then read offset 2 -> pready asserts 2 cycles after select, readdata=0x00000010, and pactive is high for 2 cycles.
REQ-038 Timer with auto-reload: CTRL=0x3, COMPARE=5 -> COUNT sequence 0..5,0,1,…; STATUS.match=1 after the first 5; irq stays 0.
REQ-039 Interrupt and W1C: CTRL=0x5, COMPARE=3 -> irq rises one cycle after match; write STATUS=1 -> match=0 and irq falls one cycle later.
REQ-040 Wrap and collisions: COUNT=0xFFFFFFFF with enable=1 -> next COUNT=0; a COUNT write of 0x100 in the same cycle as an increment yields 0x100.
REQ-041 Select and reset robustness: pselect!=SLOT_ID -> pactive stays 0 and registers are unchanged; reset asserted mid-WAIT -> no pready and COMPARE stays 0.
